// File: rtl/mmc1_serial_writer_pkg.sv
// mmc1_pkg: register selects, load width and FSM states shared by the MMC1 serial writer.
package mmc1_pkg;
  localparam logic [1:0] REG_CONTROL = 2'b00;
  localparam logic [1:0] REG_CHR0    = 2'b01;
  localparam logic [1:0] REG_CHR1    = 2'b10;
  localparam logic [1:0] REG_PRG     = 2'b11;
  localparam int LOAD_BITS = 5;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_WRITE, ST_HOLD, ST_GAP, ST_DONE} state_t;
endpackage

// File: rtl/mmc1_serial_writer_if.sv
// mmc1_serial_writer_if: command handshake plus the CPU-side cartridge bus driven by the writer.
interface mmc1_serial_writer_if;
  import mmc1_pkg::*;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_reg;
  logic [LOAD_BITS-1:0] cmd_data;
  logic                 cmd_reset;
  logic                 done;
  logic                 CPU_M2;
  logic                 nCPU_ROMSEL;
  logic                 nCPU_RW;
  logic                 CPU_A14;
  logic                 CPU_A13;
  logic                 CPU_D7;
  logic                 CPU_D0;
  modport master (
    input  cmd_valid, cmd_reg, cmd_data, cmd_reset,
    output cmd_ready, done, CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D7, CPU_D0
  );
  modport slave (
    output cmd_valid, cmd_reg, cmd_data, cmd_reset,
    input  cmd_ready, done, CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D7, CPU_D0
  );
endinterface

// File: rtl/mmc1_serial_writer_m2_phase.sv
// mmc1_m2_phase: free-running bus phase counter producing a registered M2 and phase strobes.
module mmc1_m2_phase #(
  parameter int M2_LOW  = 4,
  parameter int M2_HIGH = 4
) (
  input  logic CLK,
  input  logic nRST,
  output logic m2_o,
  output logic cyc_start_o,
  output logic cyc_last_o,
  output logic m2_rise_o
);
  localparam int T  = M2_LOW + M2_HIGH;
  localparam int PW = $clog2(T);
  logic [PW-1:0] ph_q, ph_d;
  logic          m2_q;
  always_comb ph_d = (ph_q == PW'(T - 1)) ? '0 : ph_q + 1'b1;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      ph_q <= '0;
      m2_q <= 1'b0;
    end else begin
      ph_q <= ph_d;
      m2_q <= ph_d >= PW'(M2_LOW);
    end
  assign m2_o        = m2_q;
  assign cyc_start_o = ph_q == '0;
  assign cyc_last_o  = ph_q == PW'(T - 1);
  assign m2_rise_o   = ph_q == PW'(M2_LOW - 1);
endmodule

// File: rtl/mmc1_serial_writer.sv
// mmc1_serial_writer: loads one 5-bit MMC1 register through serial bus writes on a free-running M2.
// Define MMC1_WRITER_RESET_EN to honour cmd_reset (leading D7 reset write); otherwise it is ignored.
module mmc1_serial_writer
  import mmc1_pkg::*;
#(
  parameter int M2_LOW  = 4,
  parameter int M2_HIGH = 4,
  parameter int GAP     = 1
) (
  input logic CLK,
  input logic nRST,
  mmc1_serial_writer_if.master bus
);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  state_t               state_q;
  logic [1:0]           reg_q, reg_d;
  logic [LOAD_BITS-1:0] data_q, data_d;
  logic                 rstp_q, rstp_d;
  logic [2:0]           idx_q;
  logic [GW-1:0]        gap_q;
  logic ready_q, done_q, romsel_q, rw_q, a14_q, a13_q, d7_q, d0_q;
  logic acc, start, last, wd0, m2, cyc_start, cyc_last, m2_rise;

  mmc1_m2_phase #(.M2_LOW(M2_LOW), .M2_HIGH(M2_HIGH)) u_phase (
    .CLK(CLK), .nRST(nRST), .m2_o(m2), .cyc_start_o(cyc_start),
    .cyc_last_o(cyc_last), .m2_rise_o(m2_rise)
  );

  // The *_d values let a command accepted on the last phase clock start its write immediately.
  always_comb begin
    acc    = state_q == ST_IDLE && bus.cmd_valid;
    reg_d  = acc ? bus.cmd_reg : reg_q;
    data_d = acc ? bus.cmd_data : data_q;
`ifdef MMC1_WRITER_RESET_EN
    rstp_d = acc ? bus.cmd_reset : rstp_q;
`else
    rstp_d = 1'b0;
`endif
    wd0    = !rstp_d && data_d[acc ? 3'd0 : idx_q];
    last   = !rstp_q && idx_q == 3'(LOAD_BITS - 1);
    start  = cyc_last && (acc || state_q == ST_WAIT || (state_q == ST_GAP && gap_q == '0));
  end

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q  <= ST_IDLE;
      reg_q    <= '0;
      data_q   <= '0;
      rstp_q   <= 1'b0;
      idx_q    <= '0;
      gap_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      romsel_q <= 1'b1;
      rw_q     <= 1'b1;
      a14_q    <= 1'b0;
      a13_q    <= 1'b0;
      d7_q     <= 1'b0;
      d0_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (acc) begin
          reg_q   <= reg_d;
          data_q  <= data_d;
          rstp_q  <= rstp_d;
          idx_q   <= '0;
          ready_q <= 1'b0;
          state_q <= ST_WAIT;
        end
        ST_WRITE: begin
          if (m2_rise) romsel_q <= 1'b0;
          if (cyc_last) state_q <= ST_HOLD;
        end
        // Hold clock: the mapper samples on this M2 fall, so the bus is only released afterwards.
        ST_HOLD: begin
          romsel_q <= 1'b1;
          rw_q     <= 1'b1;
          d7_q     <= 1'b0;
          d0_q     <= 1'b0;
          if (last) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            gap_q   <= GW'(GAP - 1);
            rstp_q  <= 1'b0;
            idx_q   <= idx_q + {2'b00, !rstp_q};
            state_q <= ST_GAP;
          end
        end
        ST_GAP: if (cyc_start) gap_q <= gap_q - 1'b1;
        ST_DONE: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: ;
      endcase
      if (start) begin
        state_q <= ST_WRITE;
        rw_q    <= 1'b0;
        a14_q   <= reg_d[1];
        a13_q   <= reg_d[0];
        d7_q    <= rstp_d;
        d0_q    <= wd0;
      end
    end

  assign bus.cmd_ready   = ready_q;
  assign bus.done        = done_q;
  assign bus.CPU_M2      = m2;
  assign bus.nCPU_ROMSEL = romsel_q;
  assign bus.nCPU_RW     = rw_q;
  assign bus.CPU_A14     = a14_q;
  assign bus.CPU_A13     = a13_q;
  assign bus.CPU_D7      = d7_q;
  assign bus.CPU_D0      = d0_q;
endmodule

// File: tb/tb_mmc1_serial_writer.sv
// tb_mmc1_serial_writer: drives commands into mmc1_serial_writer and checks bus writes against an MMC1 mapper model.
module tb_mmc1_serial_writer;
  import mmc1_pkg::*;
  localparam int M2_LOW = 4, M2_HIGH = 4, GAP = 1;
  localparam int T = M2_LOW + M2_HIGH, SLOT = (1 + GAP) * T;
`ifdef MMC1_WRITER_RESET_EN
  localparam bit RST_EN = 1'b1;
`else
  localparam bit RST_EN = 1'b0;
`endif
  typedef struct {int cyc; logic [1:0] a; logic d7; logic d0;} wr_t;

  logic CLK = 1'b0;
  logic nRST = 1'b1;
  mmc1_serial_writer_if bus();
  mmc1_serial_writer #(.M2_LOW(M2_LOW), .M2_HIGH(M2_HIGH), .GAP(GAP)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus)
  );
  always #5 CLK = ~CLK;

  int cyc;
  always @(posedge CLK or negedge nRST)
    if (!nRST) cyc <= 0;
    else cyc <= cyc + 1;

  // Bus monitor and mapper model: a write is taken on the M2 fall while /ROMSEL and R/W are low.
  wr_t        wq[$];
  int         dq[$];
  int         done_cnt = 0;
  int         mn = 0;
  logic       m2_prev = 1'b0;
  logic [4:0] msh = '0;
  logic [4:0] mregs [4] = '{default: 5'd0};
  always @(negedge CLK) begin
    if (!nRST) begin
      msh = '0;
      mn  = 0;
    end else if (m2_prev && !bus.CPU_M2 && !bus.nCPU_ROMSEL && !bus.nCPU_RW) begin
      wq.push_back('{cyc, {bus.CPU_A14, bus.CPU_A13}, bus.CPU_D7, bus.CPU_D0});
      if (bus.CPU_D7) begin
        msh = '0;
        mn = 0;
        mregs[0] = mregs[0] | 5'h0C;
      end else begin
        msh = {bus.CPU_D0, msh[4:1]};
        mn++;
        if (mn == 5) begin
          mregs[{bus.CPU_A14, bus.CPU_A13}] = msh;
          mn = 0;
        end
      end
    end
    if (bus.done) begin
      done_cnt++;
      dq.push_back(cyc);
    end
    m2_prev = bus.CPU_M2;
  end

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(output int k);
    int n = 0;
    while (!bus.cmd_ready && n < 300) begin @(negedge CLK); n++; end
    chk("ready_timeout", bus.cmd_ready, 1);
    k = cyc;
  endtask

  task automatic wait_done(output int dc);
    int n = 0;
    while (!bus.done && n < 3000) begin @(negedge CLK); n++; end
    chk("done_timeout", bus.done, 1);
    dc = cyc;
  endtask

  task automatic run_cmd(input logic [1:0] r, input logic [4:0] v, input bit rs);
    int k, p, dc, wb, n, st, dcnt, off, bi;
    logic d7e, d0e;
    wb = wq.size();
    dcnt = done_cnt;
    repeat ($urandom_range(0, 3)) @(negedge CLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_reg   = r;
    bus.cmd_data  = v;
    bus.cmd_reset = rs;
    wait_ready(k);
    p = k % T;
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
    bus.cmd_reg   = 2'($urandom);
    bus.cmd_data  = 5'($urandom);
    bus.cmd_reset = 1'($urandom);
    chk("ready_drop", bus.cmd_ready, 0);
    wait_done(dc);
    off = (rs && RST_EN) ? 1 : 0;
    n = LOAD_BITS + off;
    st = k + T - p;
    chk("nwrites", wq.size() - wb, n);
    for (int i = 0; i < n && wb + i < wq.size(); i++) begin
      bi  = i - off;
      d7e = bi < 0;
      d0e = (bi < 0) ? 1'b0 : v[bi];
      chk("wr_addr", wq[wb+i].a, r);
      chk("wr_d7", wq[wb+i].d7, d7e);
      chk("wr_d0", wq[wb+i].d0, d0e);
      chk("wr_time", wq[wb+i].cyc, st + i * SLOT + T);
    end
    chk("done_time", dc, st + (n - 1) * SLOT + T + 1);
    chk("model_reg", mregs[r], v);
    @(negedge CLK);
    chk("done_width", bus.done, 0);
    chk("done_count", done_cnt - dcnt, 1);
  endtask

  initial begin
    int k, dc, wb, db, got, n;
    logic [1:0] br [3];
    logic [4:0] bv [3];
    bus.cmd_valid = 1'b0;
    bus.cmd_reg   = '0;
    bus.cmd_data  = '0;
    bus.cmd_reset = 1'b0;
    #1 nRST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_outputs", {bus.cmd_ready, bus.CPU_M2, bus.nCPU_ROMSEL, bus.nCPU_RW, bus.CPU_A14,
                        bus.CPU_A13, bus.CPU_D7, bus.CPU_D0, bus.done}, 9'b1_0_1_1_0_0_0_0_0);
    nRST = 1'b1;
    @(negedge CLK);
    chk("post_rst_outputs", {bus.cmd_ready, bus.nCPU_ROMSEL, bus.nCPU_RW, bus.done}, 4'b1110);
    for (int i = 0; i < 2 * T; i++) begin
      chk("m2_phase", bus.CPU_M2, (cyc % T) >= M2_LOW);
      @(negedge CLK);
    end

    run_cmd(REG_CONTROL, 5'b01100, 1'b0);
    run_cmd(REG_PRG, 5'b10101, 1'b1);

    // Three commands with cmd_valid held high throughout.
    br = '{REG_CHR0, REG_CHR1, REG_PRG};
    for (int i = 0; i < 3; i++) bv[i] = 5'($urandom);
    wb = wq.size();
    db = dq.size();
    got = 0;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_reg = br[0];
    bus.cmd_data = bv[0];
    bus.cmd_reset = 1'b0;
    begin
      int acc [3];
      while (got < 3 && n < 3000) begin
        if (bus.cmd_ready) begin
          acc[got] = cyc;
          got++;
          @(negedge CLK);
          if (got < 3) begin
            bus.cmd_reg = br[got];
            bus.cmd_data = bv[got];
          end else bus.cmd_valid = 1'b0;
        end else @(negedge CLK);
        n++;
      end
      chk("b2b_accepts", got, 3);
      wait_done(dc);
      @(negedge CLK);
      chk("b2b_writes", wq.size() - wb, 3 * LOAD_BITS);
      chk("b2b_dones", dq.size() - db, 3);
      if (dq.size() - db >= 2) begin
        chk("b2b_accept1", acc[1], dq[db] + 1);
        chk("b2b_accept2", acc[2], dq[db+1] + 1);
      end
    end
    for (int i = wb + 1; i < wq.size(); i++)
      chk("b2b_spacing", (wq[i].cyc - wq[i-1].cyc) >= SLOT, 1);
    for (int i = 0; i < 3; i++) chk("b2b_model_reg", mregs[br[i]], bv[i]);

    // Reset pulsed during the third write.
    wb = wq.size();
    bus.cmd_valid = 1'b1;
    bus.cmd_reg = REG_CHR1;
    bus.cmd_data = 5'($urandom);
    bus.cmd_reset = 1'b0;
    wait_ready(k);
    @(negedge CLK);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!(wq.size() - wb == 2 && !bus.nCPU_RW) && n < 500) begin @(negedge CLK); n++; end
    chk("abort_in_write3", {28'd0, 3'(wq.size() - wb), bus.nCPU_RW}, {28'd0, 3'd2, 1'b0});
    nRST = 1'b0;
    #1;
    chk("abort_bus_release", {bus.nCPU_RW, bus.nCPU_ROMSEL, bus.cmd_ready}, 3'b111);
    @(negedge CLK);
    chk("abort_bus_next_clk", {bus.nCPU_RW, bus.nCPU_ROMSEL}, 2'b11);
    nRST = 1'b1;
    @(negedge CLK);
    run_cmd(REG_CHR1, 5'($urandom), 1'b0);

    // All registers and values, random reset flag, idle spacing and junk on cmd_* while busy.
    for (int r = 0; r < 4; r++)
      for (int v = 0; v < 32; v++)
        run_cmd(2'(r), 5'(v), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
